psum_buffer: RTL and testbench

//  Per-column partial-sum store between PE array row 5 and PE array row 0.

---
 rtl/psum_buffer.sv | 87 ++++++++
 tb/tb_psum_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_buffer.sv
// Per-column partial-sum store: NCOL independent FWFT FIFOs that capture row-5 psums in MODE1
// and replay them into row 0 in MODE2. Mode encoding on mode_in: 0=MODE1, 1=MODE2, 2=MODE3, 3=MODE4.
module psum_buffer #(
  parameter int PSUM_W = 16,
  parameter int DEPTH  = 16,
  parameter int NCOL   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_in,
  input  logic                     change_mode,
  input  logic                     clear,
  input  logic [NCOL-1:0]          psum_in_valid,
  input  logic [NCOL*PSUM_W-1:0]   psum_in_data,
  output logic [NCOL-1:0]          psum_buffer_ack,
  output logic [NCOL-1:0]          psum_out_valid,
  output logic [NCOL*PSUM_W-1:0]   psum_out_data,
  input  logic [NCOL-1:0]          pe_psum_ack,
  output logic [NCOL-1:0]          buf_empty,
  output logic [NCOL-1:0]          buf_full,
  output logic                     all_empty
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } mode_t;

  mode_t cur_mode;

  always_ff @(posedge clk) begin
    if (rst)
      cur_mode <= MODE1;
    else if (change_mode)
      cur_mode <= mode_t'(mode_in);
  end

  assign all_empty = &buf_empty;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    logic [PSUM_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign buf_empty[c] = (count == '0);
    assign buf_full[c]  = (count == (AW+1)'(DEPTH));

    // Ack is also held low during reset, so a PE never drops a packet the flush would discard.
    assign push = (cur_mode == MODE1) && psum_in_valid[c] && !buf_full[c] && !clear && !rst;
    assign psum_buffer_ack[c] = push;

    assign psum_out_valid[c] = (cur_mode == MODE2) && !buf_empty[c];
    assign pop = psum_out_valid[c] && pe_psum_ack[c] && !clear;
    assign psum_out_data[c*PSUM_W +: PSUM_W] = psum_out_valid[c] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= psum_in_data[c*PSUM_W +: PSUM_W];
    end

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psum_buffer.sv
// Directed bench for psum_buffer: stimulus pushes expected psums into a scoreboard queue and a
// negedge monitor pops and compares them whenever row 0 consumes a valid head entry.
module tb_psum_buffer;

  localparam int PSUM_W = 16;
  localparam int DEPTH  = 16;
  localparam int NCOL   = 7;
  localparam logic [1:0] MODE1 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd1;
  localparam logic [1:0] MODE3 = 2'd2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             mode_in;
  logic                   change_mode;
  logic                   clear;
  logic [NCOL-1:0]        psum_in_valid;
  logic [NCOL*PSUM_W-1:0] psum_in_data;
  logic [NCOL-1:0]        psum_buffer_ack;
  logic [NCOL-1:0]        psum_out_valid;
  logic [NCOL*PSUM_W-1:0] psum_out_data;
  logic [NCOL-1:0]        pe_psum_ack;
  logic [NCOL-1:0]        buf_empty;
  logic [NCOL-1:0]        buf_full;
  logic                   all_empty;

  typedef struct {
    int                col;
    logic [PSUM_W-1:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  psum_buffer #(.PSUM_W(PSUM_W), .DEPTH(DEPTH), .NCOL(NCOL)) dut (
    .clk(clk),
    .rst(rst),
    .mode_in(mode_in),
    .change_mode(change_mode),
    .clear(clear),
    .psum_in_valid(psum_in_valid),
    .psum_in_data(psum_in_data),
    .psum_buffer_ack(psum_buffer_ack),
    .psum_out_valid(psum_out_valid),
    .psum_out_data(psum_out_data),
    .pe_psum_ack(pe_psum_ack),
    .buf_empty(buf_empty),
    .buf_full(buf_full),
    .all_empty(all_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NCOL-1:0] colBit(input int col);
    logic [NCOL-1:0] m;
    m = '0;
    m[col] = 1'b1;
    return m;
  endfunction

  task automatic applyStimulus(input logic [NCOL-1:0] valid, input int col, input logic [PSUM_W-1:0] data,
                               input logic [NCOL-1:0] ack, input logic clr);
    psum_in_valid = valid;
    psum_in_data  = '0;
    psum_in_data[col*PSUM_W +: PSUM_W] = data;
    pe_psum_ack   = ack;
    clear         = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setMode(input logic [1:0] m);
    mode_in     = m;
    change_mode = 1'b1;
    stepCycle();
    change_mode = 1'b0;
  endtask

  task automatic fillCol(input int col, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(colBit(col), col, PSUM_W'(base + i), '0, 1'b0);
      @(negedge clk);
      checkOutput("fill_ack", 32'(psum_buffer_ack), 32'(colBit(col)));
      sb_q.push_back('{col, PSUM_W'(base + i)});
      stepCycle();
    end
    applyStimulus('0, 0, '0, '0, 1'b0);
  endtask

  task automatic drainCol(input int col, input int n);
    pe_psum_ack = colBit(col);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("drain_valid", 32'(psum_out_valid[col]), 32'd1);
      stepCycle();
    end
    pe_psum_ack = '0;
    @(negedge clk);
    checkOutput("drain_valid_low", 32'(psum_out_valid[col]), 32'd0);
    checkOutput("drain_empty", 32'(buf_empty[col]), 32'd1);
    stepCycle();
  endtask

  // Scoreboard monitor: each head entry consumed by row 0 must match the oldest expected psum.
  always @(negedge clk) begin
    sb_entry_t e;
    for (int c = 0; c < NCOL; c++) begin
      if (psum_out_valid[c] && pe_psum_ack[c]) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_output: col %0d data 0x%0h, expected nothing", c,
                   psum_out_data[c*PSUM_W +: PSUM_W]);
        end else begin
          e = sb_q.pop_front();
          checkOutput("out_col", 32'(c), 32'(e.col));
          checkOutput("out_data", 32'(psum_out_data[c*PSUM_W +: PSUM_W]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    rst         = 1'b1;
    mode_in     = MODE1;
    change_mode = 1'b0;
    applyStimulus('0, 0, '0, '0, 1'b0);
    stepCycle();
    stepCycle();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_ack", 32'(psum_buffer_ack), 32'h0);
    checkOutput("rst_out_valid", 32'(psum_out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(psum_out_data != '0), 32'h0);
    checkOutput("rst_buf_empty", 32'(buf_empty), 32'h7F);
    checkOutput("rst_buf_full", 32'(buf_full), 32'h0);
    checkOutput("rst_all_empty", 32'(all_empty), 32'h1);
    stepCycle();

    fillCol(3, 1, 3);
    @(negedge clk);
    checkOutput("col3_not_empty", 32'(buf_empty[3]), 32'd0);
    stepCycle();
    setMode(MODE2);
    drainCol(3, 3);
    checkOutput("col3_all_empty", 32'(buf_empty), 32'h7F);

    setMode(MODE1);
    idx = 0;
    for (int cyc = 0; cyc < DEPTH + 2; cyc++) begin
      applyStimulus(colBit(0), 0, PSUM_W'(100 + idx), '0, 1'b0);
      @(negedge clk);
      checkOutput("ovf_ack", 32'(psum_buffer_ack[0]), (idx < DEPTH) ? 32'd1 : 32'd0);
      if (idx == DEPTH)
        checkOutput("ovf_full", 32'(buf_full[0]), 32'd1);
      if (idx < DEPTH) begin
        sb_q.push_back('{0, PSUM_W'(100 + idx)});
        idx++;
      end
      stepCycle();
    end
    applyStimulus('0, 0, '0, '0, 1'b0);
    setMode(MODE2);
    drainCol(0, DEPTH);

    setMode(MODE1);
    fillCol(6, 200, 10);
    setMode(MODE2);
    drainCol(6, 10);
    setMode(MODE1);
    fillCol(6, 300, 10);
    setMode(MODE2);
    drainCol(6, 10);

    setMode(MODE1);
    fillCol(1, 'h50, 2);
    applyStimulus(colBit(1), 1, 16'h0052, '0, 1'b1);
    @(negedge clk);
    checkOutput("clear_ack", 32'(psum_buffer_ack), 32'h0);
    stepCycle();
    sb_q.delete();
    applyStimulus('0, 0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("clear_empty", 32'(buf_empty[1]), 32'd1);
    checkOutput("clear_all_empty", 32'(all_empty), 32'd1);
    stepCycle();

    fillCol(2, 'h60, 4);
    setMode(MODE2);
    pe_psum_ack = colBit(2);
    stepCycle();
    stepCycle();
    pe_psum_ack = '0;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checkOutput("midrst_empty", 32'(buf_empty), 32'h7F);
    checkOutput("midrst_all_empty", 32'(all_empty), 32'd1);
    checkOutput("midrst_out_valid", 32'(psum_out_valid), 32'h0);
    stepCycle();
    fillCol(2, 'h70, 3);

    setMode(MODE3);
    for (int cyc = 0; cyc < 3; cyc++) begin
      applyStimulus(7'h7F, 4, PSUM_W'(16'hBEEF), 7'h7F, 1'b0);
      @(negedge clk);
      checkOutput("mode3_ack", 32'(psum_buffer_ack), 32'h0);
      checkOutput("mode3_out_valid", 32'(psum_out_valid), 32'h0);
      stepCycle();
    end
    applyStimulus('0, 0, '0, '0, 1'b0);
    setMode(MODE2);
    @(negedge clk);
    checkOutput("mode2_return_valid", 32'(psum_out_valid), 32'(colBit(2)));
    stepCycle();
    drainCol(2, 3);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
